// File: rtl/bus_pkg.sv
// Shared bus-cycle types and default wait-state constants.
// Used by the address decoder and the DTACK terminator.
package bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_TMO,
    S_ACK,
    S_BERR
  } bus_state_t;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_ROM,
    REG_RAM,
    REG_IO
  } region_t;

  localparam int ROM_WAIT_DEF = 2;
  localparam int RAM_WAIT_DEF = 0;
  localparam int IO_WAIT_DEF  = 4;
  localparam int TIMEOUT_DEF  = 255;
  localparam int CNT_W_DEF    = 8;

  // ROM wins over RAM, RAM over IO
  function automatic region_t region_of(
    input logic rom,
    input logic ram,
    input logic io
  );
    if (rom)      return REG_ROM;
    else if (ram) return REG_RAM;
    else if (io)  return REG_IO;
    else          return REG_NONE;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter with enable and zero flag.
// Saturates at zero; shared by wait-state and timeout paths.
module wait_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dtack_generator.sv
// 68000 bus-cycle terminator: per-region wait states, then DTACK_N,
// or BERR_N after a timeout on unmapped accesses.
module dtack_generator
  import bus_pkg::*;
#(
  parameter int ROM_WAIT = ROM_WAIT_DEF,
  parameter int RAM_WAIT = RAM_WAIT_DEF,
  parameter int IO_WAIT  = IO_WAIT_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic CPUCLK_IN,
  input  logic RUN_IN,
  input  logic ENABLE_EXECUTE_IN,
  input  logic AS_N_IN,
  input  logic ROM_SEL_IN,
  input  logic RAM_SEL_IN,
  input  logic IO_SEL_IN,
  output logic DTACK_N,
  output logic BERR_N,
  output logic BUS_BUSY
);

  if (ROM_WAIT >= 2**CNT_W || RAM_WAIT >= 2**CNT_W ||
      IO_WAIT >= 2**CNT_W || TIMEOUT >= 2**CNT_W) begin : g_bad_width
    $error("dtack_generator: wait/timeout exceeds CNT_W");
  end
  if (TIMEOUT < 1) begin : g_bad_tmo
    $error("dtack_generator: TIMEOUT must be >= 1");
  end

  localparam logic [CNT_W-1:0] ROM_LD = CNT_W'(ROM_WAIT);
  localparam logic [CNT_W-1:0] RAM_LD = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] IO_LD  = CNT_W'(IO_WAIT);
  localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TIMEOUT - 1);

  bus_state_t       state;
  region_t          sel_region;
  logic [CNT_W-1:0] load_val;
  logic             armed;
  logic             accept;
  logic             counting;
  logic             cnt_zero;

  assign sel_region = region_of(ROM_SEL_IN, RAM_SEL_IN, IO_SEL_IN);

  always_comb begin
    load_val = TMO_LD;
    unique case (sel_region)
      REG_ROM:  load_val = ROM_LD;
      REG_RAM:  load_val = RAM_LD;
      REG_IO:   load_val = IO_LD;
      REG_NONE: load_val = TMO_LD;
      default:  load_val = TMO_LD;
    endcase
  end

  // armed requires AS to have been seen high since the last accept/reset
  assign accept = (state == S_IDLE) && !AS_N_IN &&
                  ENABLE_EXECUTE_IN && armed;

  assign counting = (state == S_WAIT || state == S_TMO) &&
                    !AS_N_IN && ENABLE_EXECUTE_IN;

  wait_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (CPUCLK_IN),
    .rst_n    (RUN_IN),
    .load     (accept),
    .load_val (load_val),
    .en       (counting),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CPUCLK_IN) begin
    if (!RUN_IN) begin
      state    <= S_IDLE;
      DTACK_N  <= 1'b1;
      BERR_N   <= 1'b1;
      BUS_BUSY <= 1'b0;
      armed    <= 1'b0;
    end else begin
      if (AS_N_IN) armed <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            armed    <= 1'b0;
            BUS_BUSY <= 1'b1;
            state    <= (sel_region == REG_NONE) ? S_TMO : S_WAIT;
          end
        end
        S_WAIT, S_TMO: begin
          if (AS_N_IN) begin
            state    <= S_IDLE;
            BUS_BUSY <= 1'b0;
          end else if (ENABLE_EXECUTE_IN && cnt_zero) begin
            if (state == S_WAIT) begin
              state   <= S_ACK;
              DTACK_N <= 1'b0;
            end else begin
              state  <= S_BERR;
              BERR_N <= 1'b0;
            end
          end
        end
        S_ACK, S_BERR: begin
          if (AS_N_IN) begin
            state    <= S_IDLE;
            DTACK_N  <= 1'b1;
            BERR_N   <= 1'b1;
            BUS_BUSY <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtack_generator.sv
// Scoreboard bench for dtack_generator: expected termination kind
// and edge index are queued at accept and checked on termination.
module tb_dtack_generator;

  logic clk = 1'b0;
  logic run, en, as_n, rom, ram, io;
  logic dtack_n, berr_n, busy;

  int edges = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit berr;
    int edge_no;
  } exp_t;

  exp_t sb[$];

  dtack_generator dut (
    .CPUCLK_IN         (clk),
    .RUN_IN            (run),
    .ENABLE_EXECUTE_IN (en),
    .AS_N_IN           (as_n),
    .ROM_SEL_IN        (rom),
    .RAM_SEL_IN        (ram),
    .IO_SEL_IN         (io),
    .DTACK_N           (dtack_n),
    .BERR_N            (berr_n),
    .BUS_BUSY          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_term(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (!dtack_n || !berr_n) found = 1'b1;
    end
  endtask

  task automatic pop_and_check(input string nm, input bit found);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    if (!found) begin
      errors++;
      $display("FAIL %s: no termination by edge %0d, expected edge %0d",
               nm, edges, e.edge_no);
      return;
    end
    if ({!berr_n, edges} !== {e.berr, e.edge_no}) begin
      errors++;
      $display("FAIL %s: got berr=%0d edge=%0d, expected berr=%0d edge=%0d",
               nm, !berr_n, edges, e.berr, e.edge_no);
    end
    checks++;
    if (!dtack_n && !berr_n) begin
      errors++;
      $display("FAIL %s_excl: dtack_n=0 berr_n=0 together", nm);
    end
  endtask

  task automatic test_reset();
    run = 0; en = 0; as_n = 1; rom = 0; ram = 0; io = 0;
    step(2);
    checks++;
    if ({dtack_n, berr_n, busy} !== 3'b110) begin
      errors++;
      $display("FAIL reset: got %b, expected 110", {dtack_n, berr_n, busy});
    end
    run = 1;
    step();
  endtask

  task automatic test_ram();
    bit found;
    int a;
    ram = 1; as_n = 0; en = 1;
    a = edges + 1;
    sb.push_back('{1'b0, a + 1});
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ram_busy: got %b, expected 1", busy);
    end
    wait_term(10, found);
    pop_and_check("ram_term", found);
    step(2);
    checks++;
    if (dtack_n !== 1'b0) begin
      errors++;
      $display("FAIL ram_hold: dtack_n=%b, expected 0", dtack_n);
    end
    as_n = 1;
    step();
    checks++;
    if ({dtack_n, busy} !== 2'b10) begin
      errors++;
      $display("FAIL ram_release: got %b, expected 10", {dtack_n, busy});
    end
    ram = 0;
  endtask

  task automatic test_io_pause();
    bit found;
    int a;
    io = 1; as_n = 0; en = 1;
    a = edges + 1;
    sb.push_back('{1'b0, a + 15});
    step();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      en = !(edges >= a + 2 && edges < a + 12);
      step();
      if (!dtack_n || !berr_n) found = 1'b1;
    end
    pop_and_check("io_pause", found);
    en = 1; as_n = 1;
    step();
    io = 0;
  endtask

  task automatic test_timeout();
    bit found;
    int a;
    as_n = 0; en = 1;
    a = edges + 1;
    sb.push_back('{1'b1, a + 255});
    step();
    wait_term(300, found);
    pop_and_check("timeout", found);
    as_n = 1;
    step();
    checks++;
    if ({dtack_n, berr_n, busy} !== 3'b110) begin
      errors++;
      $display("FAIL tmo_release: got %b, expected 110",
               {dtack_n, berr_n, busy});
    end
  endtask

  task automatic test_rom_priority();
    bit found;
    int a;
    rom = 1; io = 1; as_n = 0; en = 1;
    a = edges + 1;
    sb.push_back('{1'b0, a + 3});
    step();
    io = 0;
    wait_term(20, found);
    pop_and_check("rom_prio", found);
    as_n = 1;
    step();
    rom = 0;
  endtask

  task automatic test_abort();
    bit found;
    int a;
    rom = 1; as_n = 0; en = 1;
    step();
    as_n = 1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b, expected 0", busy);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dtack_n !== 1'b1) begin
        errors++;
        $display("FAIL abort_nopulse: dtack_n=%b, expected 1", dtack_n);
      end
    end
    rom = 0; ram = 1; as_n = 0;
    a = edges + 1;
    sb.push_back('{1'b0, a + 1});
    step();
    wait_term(10, found);
    pop_and_check("abort_next", found);
    as_n = 1;
    step();
    ram = 0;
  endtask

  task automatic test_run_reset();
    bit found;
    int a;
    ram = 1; as_n = 0; en = 1;
    a = edges + 1;
    sb.push_back('{1'b0, a + 1});
    step();
    wait_term(10, found);
    pop_and_check("run_pre", found);
    run = 0;
    step();
    checks++;
    if ({dtack_n, berr_n, busy} !== 3'b110) begin
      errors++;
      $display("FAIL run_reset: got %b, expected 110",
               {dtack_n, berr_n, busy});
    end
    run = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({dtack_n, busy} !== 2'b10) begin
        errors++;
        $display("FAIL run_noaccept: got %b, expected 10", {dtack_n, busy});
      end
    end
    as_n = 1;
    step();
    as_n = 0;
    a = edges + 1;
    sb.push_back('{1'b0, a + 1});
    step();
    wait_term(10, found);
    pop_and_check("run_reaccept", found);
    as_n = 1;
    step();
    ram = 0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_io_pause();
    test_timeout();
    test_rom_priority();
    test_abort();
    test_run_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
